rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter TILE_BASE, default 25'h40000, first byte address of the tile-ROM region; lower addresses are CPU/sound/sprite ROM.
REQ-002 Parameter FIFO_DEPTH, default 4, the number of byte entries buffered between the download stream and the SDRAM ports; power of two, at least 2.
REQ-003 clk_sys  in  1  system clock; the one clock.
REQ-004 reset  in  1  reset, synchronous to clk_sys and active-high.
REQ-005 ioctl_downl  in  1  high while a ROM download is in progress.
REQ-006 ioctl_wr  in  1  byte strobe; one byte per rising edge.
REQ-007 ioctl_addr  in  25  byte address of ioctl_dout.
REQ-008 ioctl_dout  in  8  download byte.
REQ-009 port1_req / port2_req  out  1 each  toggle request to the SDRAM port.
REQ-010 port1_ack / port2_ack  in  1 each  toggle acknowledge from the SDRAM (sdram clock domain).
REQ-011 port1_a / port2_a  out  23 each  word address.
REQ-012 port1_ds / port2_ds  out  2 each  byte enables {hi,lo}.
REQ-013 port1_d / port2_d  out  16 each  write data, {byte,byte}.
REQ-014 port1_we / port2_we  out  1 each  write enable; equals ioctl_downl or an active flush.
REQ-015 rom_loaded  out  1  all downloaded bytes committed to SDRAM.
REQ-016 overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.

Function
REQ-017 Each ack shall pass through a 2-flop synchronizer before it is used; a port is idle when req equals its synchronized ack.
REQ-018 A 0->1 edge of ioctl_wr while ioctl_downl=1 shall push {addr, dout} into the FIFO in the following cycle.
REQ-019 An edge that arrives while the FIFO is full shall be dropped and shall set overflow; a push and a pop in the same cycle when full shall be accepted.
REQ-020 Decode: addr<TILE_BASE targets port1 with a=addr[23:1]; otherwise the byte targets port2 with a=(addr-TILE_BASE)[23:1], computed in 25 bits.
REQ-021 ds={addr[0],~addr[0]} and d={dout,dout}, using the address after any offset is applied.
REQ-022 Drain FSM states: IDLE, ISSUE, WAIT_ACK.
REQ-023 IDLE->ISSUE when the FIFO is non-empty and the target port of the head entry is idle.
REQ-024 ISSUE: register a/ds/d, toggle req, pop the FIFO, then go to WAIT_ACK; a/ds/d shall hold stable until the ack matches.
REQ-025 WAIT_ACK->IDLE when the synchronized ack equals req; the next request shall not issue before that cycle.
REQ-026 At most one request shall be outstanding across both ports; entries commit in strict FIFO order.
REQ-027 Minimum spacing from push to req toggle is 2 cycles.
REQ-028 rom_loaded shall clear on a 0->1 edge of ioctl_downl.
REQ-029 After a 1->0 edge of ioctl_downl, rom_loaded shall set on the first cycle in which the FIFO is empty and the FSM is in IDLE.
REQ-030 While draining after ioctl_downl falls, port*_we shall remain 1 until rom_loaded sets.
REQ-031 overflow shall clear only on reset or a new download edge.

Reset
REQ-032 On reset: the FIFO is emptied, the FSM goes to IDLE, rom_loaded=0, overflow=0, port*_req=0, a/ds/d=0, and the synchronizers=0.
REQ-033 When reset is asserted mid-transaction, the pending entry is abandoned; after reset, no request shall issue until that port's synchronized ack equals req.

Structure
REQ-034 Package rom_loader_pkg shall hold the FIFO entry typedef {addr[24:0], data[7:0]}, the FSM state enum and the TILE_BASE default.
REQ-035 Sub-module ldr_fifo: a synchronous FIFO with push/pop/full/empty, parameterised by depth and entry type.

Verification
REQ-036 Scenario 1: ioctl_downl=1, write byte 0xA5 at 0x00003 -> port1: a=1, ds=2'b10, d=16'hA5A5, req toggles once; port2 stays quiet.
REQ-037 Scenario 2: byte 0x3C at 0x40000 -> port2: a=0, ds=2'b01, d=16'h3C3C; port1_req unchanged.
REQ-038 Scenario 3: ack held off, 6 back-to-back writes with FIFO_DEPTH=4 -> 1 in flight, 4 buffered, sixth byte dropped, overflow=1; on release, 5 requests in order.
REQ-039 Scenario 4: ioctl_downl falls with 3 entries pending -> rom_loaded stays 0 until the third ack syncs, then is 1 the next cycle; we stays high until then.
REQ-040 Scenario 5: reset pulsed during WAIT_ACK -> all outputs return to reset values; the following download starts only once ack equals req.
REQ-041 Scenario 6: alternating port1/port2 addresses -> never two outstanding requests; the ack-to-next-req gap is at least 1 cycle.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// rtl/rom_loader_pkg.sv - shared types and defaults for the ROM download loader
package rom_loader_pkg;

   localparam logic [24:0] TILE_BASE_DEFAULT = 25'h40000;

   typedef struct packed {
      logic [24:0] addr;
      logic [7:0]  data;
   } ldr_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACK
   } ldr_state_t;

   function automatic logic is_tile(input logic [24:0] addr, input logic [24:0] base);
      return addr >= base;
   endfunction

endpackage

// File: rtl/ldr_fifo.sv
// rtl/ldr_fifo.sv - synchronous FIFO buffering download bytes ahead of the SDRAM ports
module ldr_fifo #(
   parameter int  DEPTH   = 4,
   parameter type entry_t = logic [7:0]
) (
   input  logic   clk_sys,
   input  logic   reset,
   input  logic   push,
   input  entry_t push_data,
   input  logic   pop,
   output entry_t pop_data,
   output logic   full,
   output logic   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   entry_t         mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           do_push;
   logic           do_pop;

   assign full     = (count == DEPTH_W);
   assign empty    = (count == '0);
   assign do_pop   = pop & ~empty;
   // A push into a full FIFO is still taken when the head leaves in the same cycle.
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   // Entry storage; contents need no reset since count guards every read.
   always_ff @(posedge clk_sys) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - steers ioctl download bytes into two toggle-handshake SDRAM ports
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter logic [24:0] TILE_BASE  = TILE_BASE_DEFAULT,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_downl,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        port1_req,
   input  logic        port1_ack,
   output logic [22:0] port1_a,
   output logic [1:0]  port1_ds,
   output logic [15:0] port1_d,
   output logic        port1_we,
   output logic        port2_req,
   input  logic        port2_ack,
   output logic [22:0] port2_a,
   output logic [1:0]  port2_ds,
   output logic [15:0] port2_d,
   output logic        port2_we,
   output logic        rom_loaded,
   output logic        overflow
);

   logic        ack1_meta, ack1_sync;
   logic        ack2_meta, ack2_sync;
   logic        wr_d, downl_d;
   logic        downl_rise, downl_fall;
   logic        flushing;
   logic        push, pop, full, empty, drop;
   logic        port1_idle, port2_idle;
   logic        head_tile, cur_tile, target_idle;
   logic [24:0] head_off;
   logic        unused_head_msb;
   ldr_entry_t  push_entry, head;
   ldr_state_t  state, state_nxt;

   // Bring both acks from the SDRAM clock domain through two flops.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         ack1_meta <= 1'b0;
         ack1_sync <= 1'b0;
         ack2_meta <= 1'b0;
         ack2_sync <= 1'b0;
      end else begin
         ack1_meta <= port1_ack;
         ack1_sync <= ack1_meta;
         ack2_meta <= port2_ack;
         ack2_sync <= ack2_meta;
      end
   end

   assign port1_idle = (port1_req == ack1_sync);
   assign port2_idle = (port2_req == ack2_sync);

   // Delayed copies of the ioctl strobes for edge detection.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_d    <= 1'b0;
         downl_d <= 1'b0;
      end else begin
         wr_d    <= ioctl_wr;
         downl_d <= ioctl_downl;
      end
   end

   assign downl_rise = ioctl_downl & ~downl_d;
   assign downl_fall = ~ioctl_downl & downl_d;
   assign push       = ioctl_wr & ~wr_d & ioctl_downl;
   assign push_entry = '{addr: ioctl_addr, data: ioctl_dout};
   assign drop       = push & full & ~pop;

   ldr_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (ldr_entry_t)
   ) u_fifo (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head),
      .full      (full),
      .empty     (empty)
   );

   // Tile bytes are rebased so the tile ROM starts at word 0 of port2.
   assign head_tile       = is_tile(head.addr, TILE_BASE);
   assign head_off        = head_tile ? (head.addr - TILE_BASE) : head.addr;
   assign target_idle     = head_tile ? port2_idle : port1_idle;
   assign unused_head_msb = head_off[24];

   // Drain FSM state register.
   always_ff @(posedge clk_sys) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Drain FSM: one request in flight at a time across both ports.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty && target_idle) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            pop       = 1'b1;
            state_nxt = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (cur_tile ? port2_idle : port1_idle) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Port address/data/request registers, loaded only when a request issues.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cur_tile  <= 1'b0;
         port1_req <= 1'b0;
         port1_a   <= '0;
         port1_ds  <= '0;
         port1_d   <= '0;
         port2_req <= 1'b0;
         port2_a   <= '0;
         port2_ds  <= '0;
         port2_d   <= '0;
      end else if (state == ST_ISSUE) begin
         cur_tile <= head_tile;
         if (head_tile) begin
            port2_a   <= head_off[23:1];
            port2_ds  <= {head_off[0], ~head_off[0]};
            port2_d   <= {head.data, head.data};
            port2_req <= ~port2_req;
         end else begin
            port1_a   <= head_off[23:1];
            port1_ds  <= {head_off[0], ~head_off[0]};
            port1_d   <= {head.data, head.data};
            port1_req <= ~port1_req;
         end
      end
   end

   // Download completion tracking and the sticky overflow flag.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rom_loaded <= 1'b0;
         flushing   <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (downl_rise) begin
            rom_loaded <= 1'b0;
            flushing   <= 1'b0;
         end else if (downl_fall) begin
            flushing <= 1'b1;
         end else if (flushing && empty && state == ST_IDLE) begin
            rom_loaded <= 1'b1;
            flushing   <= 1'b0;
         end
         if (drop)            overflow <= 1'b1;
         else if (downl_rise) overflow <= 1'b0;
      end
   end

   // Write enable covers the falling-edge cycle so it never dips mid-drain.
   assign port1_we = ioctl_downl | flushing | downl_fall;
   assign port2_we = ioctl_downl | flushing | downl_fall;

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - directed self-checking bench for rom_loader
module tb_rom_loader;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_downl;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        port1_req, port2_req;
   logic        port1_ack, port2_ack;
   logic [22:0] port1_a, port2_a;
   logic [1:0]  port1_ds, port2_ds;
   logic [15:0] port1_d, port2_d;
   logic        port1_we, port2_we;
   logic        rom_loaded, overflow;

   typedef struct {
      int          port;
      logic [22:0] a;
      logic [1:0]  ds;
      logic [15:0] d;
   } rec_t;

   rec_t recs[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   last_ack_cyc = 0;
   int   min_gap = 1000;
   int   viol = 0;
   int   lat1 = 0, lat2 = 0;
   logic ack_hold = 1'b0;
   logic p1_req_q = 1'b0, p2_req_q = 1'b0;

   rom_loader dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .ioctl_downl (ioctl_downl),
      .ioctl_wr    (ioctl_wr),
      .ioctl_addr  (ioctl_addr),
      .ioctl_dout  (ioctl_dout),
      .port1_req   (port1_req),
      .port1_ack   (port1_ack),
      .port1_a     (port1_a),
      .port1_ds    (port1_ds),
      .port1_d     (port1_d),
      .port1_we    (port1_we),
      .port2_req   (port2_req),
      .port2_ack   (port2_ack),
      .port2_a     (port2_a),
      .port2_ds    (port2_ds),
      .port2_d     (port2_d),
      .port2_we    (port2_we),
      .rom_loaded  (rom_loaded),
      .overflow    (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   // SDRAM stand-in: logs each request toggle, then acks after 3 cycles unless held.
   initial begin
      port1_ack = 1'b0;
      port2_ack = 1'b0;
      forever begin
         rec_t r;
         @(negedge clk_sys);
         if (!reset) begin
            if (port1_req != p1_req_q) begin
               r.port = 1; r.a = port1_a; r.ds = port1_ds; r.d = port1_d;
               recs.push_back(r);
               if (cyc - last_ack_cyc < min_gap) min_gap = cyc - last_ack_cyc;
            end
            if (port2_req != p2_req_q) begin
               r.port = 2; r.a = port2_a; r.ds = port2_ds; r.d = port2_d;
               recs.push_back(r);
               if (cyc - last_ack_cyc < min_gap) min_gap = cyc - last_ack_cyc;
            end
         end
         p1_req_q = port1_req;
         p2_req_q = port2_req;
         if ((port1_req != port1_ack) && (port2_req != port2_ack)) viol++;
         if (port1_req != port1_ack && !ack_hold) begin
            lat1++;
            if (lat1 >= 3) begin port1_ack = port1_req; lat1 = 0; last_ack_cyc = cyc; end
         end else lat1 = 0;
         if (port2_req != port2_ack && !ack_hold) begin
            lat2++;
            if (lat2 >= 3) begin port2_ack = port2_req; lat2 = 0; last_ack_cyc = cyc; end
         end else lat2 = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk_sys);
   endtask

   task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
      @(negedge clk_sys);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr   = 1'b0;
   endtask

   task automatic wait_recs(input string tag, input int n, input int budget);
      int k = 0;
      while (recs.size() < n && k < budget) begin
         @(negedge clk_sys);
         k++;
      end
      check(tag, recs.size(), n);
   endtask

   task automatic check_rec(input string tag, input int idx, input int port,
                            input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
      if (idx >= recs.size()) begin
         check({tag, "_present"}, recs.size(), idx + 1);
      end else begin
         check({tag, "_port"}, recs[idx].port, port);
         check({tag, "_a"},    {9'd0, recs[idx].a}, {9'd0, a});
         check({tag, "_ds"},   {30'd0, recs[idx].ds}, {30'd0, ds});
         check({tag, "_d"},    {16'd0, recs[idx].d}, {16'd0, d});
      end
   endtask

   task automatic wait_loaded(output int seen_cyc, output int we_drops);
      int k = 0;
      we_drops = 0;
      while (!rom_loaded && k < 300) begin
         if (!port1_we || !port2_we) we_drops++;
         @(negedge clk_sys);
         k++;
      end
      seen_cyc = cyc;
   endtask

   initial begin
      int lc, wd, dly;
      reset       = 1'b1;
      ioctl_downl = 1'b0;
      ioctl_wr    = 1'b0;
      ioctl_addr  = '0;
      ioctl_dout  = '0;
      wait_cycles(3);
      reset = 1'b0;
      wait_cycles(1);

      check("rst_p1_req", port1_req, 0);
      check("rst_p2_req", port2_req, 0);
      check("rst_p1_a",   port1_a, 0);
      check("rst_p2_ds",  port2_ds, 0);
      check("rst_p2_d",   port2_d, 0);
      check("rst_loaded", rom_loaded, 0);
      check("rst_ovf",    overflow, 0);

      // Scenario 1: single port1 byte
      ioctl_downl = 1'b1;
      write_byte(25'h00003, 8'hA5);
      wait_recs("s1_count", 1, 50);
      check_rec("s1", 0, 1, 23'd1, 2'b10, 16'hA5A5);
      check("s1_we", port1_we, 1);
      wait_cycles(20);
      check("s1_p2_quiet", port2_req, 0);
      check("s1_single",   recs.size(), 1);

      // Scenario 2: tile-region byte rebased onto port2
      write_byte(25'h40000, 8'h3C);
      wait_recs("s2_count", 2, 50);
      check_rec("s2", 1, 2, 23'd0, 2'b01, 16'h3C3C);
      check("s2_p1_req", port1_req, 1);
      wait_cycles(20);

      // Scenario 3: ack held, six back-to-back bytes, last one dropped
      ack_hold = 1'b1;
      for (int i = 0; i < 5; i++) write_byte(25'h10 + 25'(i), 8'h10 + 8'(i));
      check("s3_ovf_before", overflow, 0);
      write_byte(25'h15, 8'h15);
      check("s3_ovf_after", overflow, 1);
      check("s3_inflight",  recs.size(), 3);
      ack_hold = 1'b0;
      wait_recs("s3_count", 7, 300);
      check_rec("s3_0", 2, 1, 23'h08, 2'b01, 16'h1010);
      check_rec("s3_1", 3, 1, 23'h08, 2'b10, 16'h1111);
      check_rec("s3_2", 4, 1, 23'h09, 2'b01, 16'h1212);
      check_rec("s3_3", 5, 1, 23'h09, 2'b10, 16'h1313);
      check_rec("s3_4", 6, 1, 23'h0A, 2'b01, 16'h1414);
      wait_cycles(30);
      check("s3_no_extra", recs.size(), 7);

      // Scenario 4: download ends with three bytes pending
      ack_hold = 1'b1;
      write_byte(25'h20, 8'h01);
      write_byte(25'h21, 8'h02);
      write_byte(25'h22, 8'h03);
      @(negedge clk_sys);
      ioctl_downl = 1'b0;
      wait_cycles(5);
      check("s4_loaded_held", rom_loaded, 0);
      check("s4_we_held",     port1_we, 1);
      check("s4_ovf_sticky",  overflow, 1);
      ack_hold = 1'b0;
      wait_loaded(lc, wd);
      check("s4_loaded",  rom_loaded, 1);
      check("s4_we_gap",  wd, 0);
      check("s4_count",   recs.size(), 10);
      dly = lc - last_ack_cyc;
      check("s4_delay_ok", (dly >= 3 && dly <= 5), 1);
      wait_cycles(1);
      check("s4_we_off",  port1_we, 0);

      // Scenario 5: reset during WAIT_ACK
      ioctl_downl = 1'b1;
      wait_cycles(2);
      check("s5_loaded_clr", rom_loaded, 0);
      check("s5_ovf_clr",    overflow, 0);
      ack_hold = 1'b1;
      write_byte(25'h30, 8'h77);
      wait_recs("s5_count_a", 11, 50);
      @(negedge clk_sys);
      reset = 1'b1;
      wait_cycles(2);
      reset = 1'b0;
      wait_cycles(1);
      check("s5_p1_req", port1_req, 0);
      check("s5_p2_req", port2_req, 0);
      check("s5_p1_a",   port1_a, 0);
      check("s5_p1_ds",  port1_ds, 0);
      check("s5_p1_d",   port1_d, 0);
      check("s5_loaded", rom_loaded, 0);
      wait_cycles(4);
      write_byte(25'h40, 8'h55);
      wait_cycles(20);
      check("s5_blocked", recs.size(), 11);
      ack_hold = 1'b0;
      wait_recs("s5_count_b", 12, 100);
      check_rec("s5", 11, 1, 23'h20, 2'b01, 16'h5555);
      wait_cycles(30);

      // Scenario 6: alternating ports
      viol    = 0;
      min_gap = 1000;
      write_byte(25'h00050, 8'hC1);
      write_byte(25'h40050, 8'hC2);
      write_byte(25'h00052, 8'hC3);
      write_byte(25'h40052, 8'hC4);
      wait_recs("s6_count", 16, 300);
      check_rec("s6_0", 12, 1, 23'h28, 2'b01, 16'hC1C1);
      check_rec("s6_1", 13, 2, 23'h28, 2'b01, 16'hC2C2);
      check_rec("s6_2", 14, 1, 23'h29, 2'b01, 16'hC3C3);
      check_rec("s6_3", 15, 2, 23'h29, 2'b01, 16'hC4C4);
      check("s6_one_outstanding", viol, 0);
      check("s6_gap_ok", (min_gap >= 1), 1);

      ioctl_downl = 1'b0;
      wait_loaded(lc, wd);
      check("end_loaded", rom_loaded, 1);
      check("end_we_gap", wd, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
